inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have parameter IM_AW, default 10, giving the instruction-memory word-address width.
REQ-002 The block SHALL have parameter RESET_PC, default 0, giving the first fetch address after reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port IM_read, output, 1 bit: read request to instruction memory.
REQ-006 Port IM_addr, output, IM_AW bits: word address of the request.
REQ-007 Port IM_out, input, 32 bits: memory read data, valid one cycle after the request.
REQ-008 Port if_valid, output, 1 bit: instruction available to decode.
REQ-009 Port if_inst, output, 32 bits: instruction word.
REQ-010 Port if_pc, output, IM_AW bits: word address of if_inst.
REQ-011 Port id_ready, input, 1 bit: decode accepts; a transfer occurs when if_valid and id_ready are both 1.
REQ-012 Port br_valid, input, 1 bit: redirect request (branch or jump).
REQ-013 Port br_target, input, IM_AW bits: redirect word address.

Function
REQ-014 FSM states SHALL be S_BOOT (entered on reset, no request) and S_RUN; S_BOOT moves to S_RUN unconditionally on the next edge.
REQ-015 The block SHALL keep pc, a 1-bit in-flight flag with its pc tag, and a 2-entry FIFO of {pc, inst}.
REQ-016 In S_RUN it SHALL assert IM_read when (fifo_count - pop + inflight) < 2, where pop = if_valid && id_ready; IM_addr = pc.
REQ-017 On an issued read, pc SHALL advance to pc+1 modulo 2^IM_AW (wrap from all-ones to 0), and inflight SHALL be set with tag pc.
REQ-018 On the cycle after an issue, IM_out SHALL be written to the FIFO tail with the stored tag, and inflight SHALL clear unless a new read issues.
REQ-019 if_valid SHALL equal (fifo_count != 0); if_inst and if_pc SHALL show the FIFO head; request to if_valid latency is 2 cycles.
REQ-020 With id_ready held at 1 and no redirect, the block SHALL sustain one instruction per cycle.
REQ-021 When the FIFO is full and no pop occurs, it SHALL hold IM_read at 0 and keep head and pc stable; no data SHALL be lost or duplicated.
REQ-022 When a push and a pop occur in the same cycle, fifo_count SHALL stay unchanged.
REQ-023 On br_valid in S_RUN, in that cycle the block SHALL empty the FIFO, drop any in-flight result, drive IM_read=1 with IM_addr=br_target, and load pc with br_target+1.
REQ-024 if_valid SHALL be 0 in the cycle after br_valid; the first post-redirect instruction SHALL appear 2 cycles after br_valid.
REQ-025 br_valid SHALL take priority over id_ready; any pop signalled in the br_valid cycle SHALL count as a transfer.
REQ-026 br_valid in S_BOOT SHALL set pc to br_target and SHALL NOT issue a read.
REQ-027 When IM_read is 0, IM_addr SHALL hold its previous value.

Reset
REQ-028 While rst=1: IM_read=0, IM_addr=0, if_valid=0, if_inst=0, if_pc=0, fifo_count=0, inflight=0, pc=RESET_PC, state=S_BOOT.
REQ-029 A reset asserted mid-stream SHALL discard all FIFO and in-flight contents; the first request after rst falls SHALL occur one cycle later, at RESET_PC.

Structure
REQ-030 Instruction width 32, FIFO depth 2, and the FSM state enum SHALL live in the shared pipeline package; IM_AW SHALL default from the package instruction-memory address width.
REQ-031 The 2-entry FIFO SHALL be a sub-module fetch_fifo (push, pop, flush, count, head); the FSM, pc and in-flight logic SHALL stay in inst_fetch.

Verification
REQ-032 Reset, then id_ready=1, memory word k = 0x1000_0000+k: if_valid first rises 3 cycles after rst falls (1 boot cycle + 2 latency); if_pc = 0,1,2,... with if_inst = 0x10000000, 0x10000001, ...
REQ-033 Stream running, id_ready=0 for 5 cycles: IM_read stops after the FIFO fills (count=2); after release, the pc sequence continues with no gap or repeat.
REQ-034 br_valid=1 with br_target=0x2A while the FIFO holds 2 entries: next cycle if_valid=0; one cycle later if_pc=0x2A, followed by 0x2B.
REQ-035 IM_AW=4, start at pc 0xE: if_pc sequence is 0xE, 0xF, 0x0, 0x1.
REQ-036 rst asserted for 1 cycle mid-stream with 2 buffered entries: no stale entry is delivered; the sequence restarts at RESET_PC.
REQ-037 Random id_ready (50%) and br_valid (5%) against a reference model: every delivered {if_pc, if_inst} matches memory and program order since the last redirect.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: instruction
// width, fetch-buffer depth, default memory address width and FSM states.
package inst_fetch_pkg;

  localparam int unsigned INST_W        = 32;
  localparam int unsigned FIFO_DEPTH    = 2;
  localparam int unsigned FIFO_CNT_W    = 2;
  localparam int unsigned IM_AW_DEFAULT = 10;

  typedef enum logic [0:0] {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_e;

  localparam logic [FIFO_CNT_W:0] OCC_LIMIT = (FIFO_CNT_W+1)'(FIFO_DEPTH);

  // True when the buffer, after this cycle's pop and the result still in
  // flight, leaves a free slot for one more memory response.
  function automatic logic room_for_issue(
    input logic [FIFO_CNT_W-1:0] count,
    input logic                  pop,
    input logic                  inflight
  );
    logic [FIFO_CNT_W:0] occ;
    occ = {1'b0, count} - {{FIFO_CNT_W{1'b0}}, pop} + {{FIFO_CNT_W{1'b0}}, inflight};
    return occ < OCC_LIMIT;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer holding {pc, inst}. Entry 0 is always the head, so
// a pop shifts entry 1 down; flush empties the buffer and wins over push/pop.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DW = IM_AW_DEFAULT + INST_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DW-1:0]         data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [FIFO_CNT_W-1:0] count_o,
  output logic [DW-1:0]         head_o
);

  localparam logic [FIFO_CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [FIFO_CNT_W-1:0] CNT_ONE  = FIFO_CNT_W'(1);
  localparam logic [FIFO_CNT_W-1:0] CNT_FULL = FIFO_CNT_W'(FIFO_DEPTH);

  logic [DW-1:0]         ent0_q, ent0_d;
  logic [DW-1:0]         ent1_q, ent1_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  doPop;
  logic                  doPush;

  // Next-state: a pop from an empty buffer or a push into a full one with no
  // matching pop are ignored so the occupancy can never go out of range.
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    doPop   = pop_i && (count_q != CNT_ZERO);
    doPush  = push_i && ((count_q != CNT_FULL) || doPop);
    if (flush_i) begin
      count_d = CNT_ZERO;
    end else begin
      case ({doPush, doPop})
        2'b10: begin
          if (count_q == CNT_ZERO) begin
            ent0_d = data_i;
          end else begin
            ent1_d = data_i;
          end
          count_d = count_q + CNT_ONE;
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - CNT_ONE;
        end
        2'b11: begin
          if (count_q == CNT_ONE) begin
            ent0_d = data_i;
          end else begin
            ent0_d = ent1_q;
            ent1_d = data_i;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= CNT_ZERO;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = ent0_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues word reads to a one-cycle-latency memory,
// tags each response with its pc, buffers up to two instructions for decode
// and handles branch/jump redirects by flushing and refetching.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned      IM_AW    = IM_AW_DEFAULT,
  parameter logic [IM_AW-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              IM_read,
  output logic [IM_AW-1:0]  IM_addr,
  input  logic [INST_W-1:0] IM_out,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [IM_AW-1:0]  if_pc,
  input  logic              id_ready,
  input  logic              br_valid,
  input  logic [IM_AW-1:0]  br_target
);

  localparam int unsigned     DW      = IM_AW + INST_W;
  localparam logic [IM_AW-1:0] PC_STEP = IM_AW'(1);

  fetch_state_e          state_q, state_d;
  logic [IM_AW-1:0]      pc_q, pc_d;
  logic                  infl_q, infl_d;
  logic [IM_AW-1:0]      tag_q, tag_d;
  logic [IM_AW-1:0]      addr_q, addr_d;

  logic                  issue;
  logic [IM_AW-1:0]      reqAddr;
  logic                  pop;
  logic                  push;
  logic                  flush;
  logic [FIFO_CNT_W-1:0] fifoCount;
  logic [DW-1:0]         fifoHead;

  fetch_fifo #(
    .DW (DW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  ({tag_q, IM_out}),
    .pop_i   (pop),
    .flush_i (flush),
    .count_o (fifoCount),
    .head_o  (fifoHead)
  );

  // Decode-facing outputs are forced quiet during reset so stale buffer
  // contents never leak out in the cycle reset is first seen.
  assign if_valid = !rst && (fifoCount != '0);
  assign if_pc    = rst ? '0 : fifoHead[DW-1:INST_W];
  assign if_inst  = rst ? '0 : fifoHead[INST_W-1:0];
  assign pop      = if_valid && id_ready;

  // FSM, pc and in-flight tracking. A redirect overrides normal flow: it
  // drops the buffer and the response arriving this cycle, then fetches
  // the target immediately.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    infl_d  = 1'b0;
    tag_d   = tag_q;
    addr_d  = addr_q;
    issue   = 1'b0;
    reqAddr = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
        if (br_valid) begin
          pc_d = br_target;
        end
      end
      S_RUN: begin
        if (br_valid) begin
          flush   = 1'b1;
          issue   = 1'b1;
          reqAddr = br_target;
          pc_d    = br_target + PC_STEP;
        end else begin
          push = infl_q;
          if (room_for_issue(fifoCount, pop, infl_q)) begin
            issue = 1'b1;
            pc_d  = pc_q + PC_STEP;
          end
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
    if (issue) begin
      infl_d = 1'b1;
      tag_d  = reqAddr;
      addr_d = reqAddr;
    end
  end

  // Memory request port; the address holds its last issued value when idle.
  assign IM_read = issue && !rst;
  assign IM_addr = rst ? '0 : (issue ? reqAddr : addr_q);

  // State registers for the FSM, pc, in-flight flag/tag and last address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      infl_q  <= 1'b0;
      tag_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      infl_q  <= infl_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
    end
  end

endmodule
